mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning line-memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 SHALL have parameter STARVE_MAX, default 8, meaning host wait cycles before forced grant (range 1..255).
REQ-004 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_core_re  input  1  core load request.
REQ-007 SHALL have port i_core_we  input  1  core store request.
REQ-008 SHALL have port i_core_addr  input  32  core byte-independent word address.
REQ-009 SHALL have port i_core_wdata  input  DATA_W  core store data.
REQ-010 SHALL have port o_core_stall  output  1  core request not accepted this cycle; core holds request.
REQ-011 SHALL have port o_core_rdata  output  DATA_W  core load data.
REQ-012 SHALL have port o_core_rvld  output  1  core load data valid.
REQ-013 SHALL have port o_addr_err  output  1  one-cycle pulse: core address out of range.
REQ-014 SHALL have port i_host_req  input  1  host (loader/debug) access request.
REQ-015 SHALL have port i_host_we  input  1  host write (1) / read (0).
REQ-016 SHALL have port i_host_addr  input  ADDR_W  host address.
REQ-017 SHALL have port i_host_wdata  input  DATA_W  host write data.
REQ-018 SHALL have port o_host_gnt  output  1  host access issued this cycle.
REQ-019 SHALL have port o_host_rdata  output  DATA_W  host read data.
REQ-020 SHALL have port o_host_rvld  output  1  host read data valid.
REQ-021 SHALL have ports o_mem_re, o_mem_we (1), o_mem_addr (ADDR_W), o_mem_wdata (DATA_W) outputs, and i_mem_rdata (DATA_W) input; memory read latency exactly 1 cycle.

Function
REQ-022 SHALL issue at most one memory access per cycle; owner per cycle is NONE, CORE or HOST.
REQ-023 SHALL, absent forced host grant, give CORE priority when i_core_re|i_core_we; HOST otherwise when i_host_req.
REQ-024 SHALL treat i_core_re and i_core_we both high as a store only.
REQ-025 SHALL keep starve counter: +1 each cycle i_host_req high and not granted, saturating at STARVE_MAX; cleared on grant or when i_host_req low.
REQ-026 SHALL, when counter == STARVE_MAX and i_host_req, grant HOST and assert o_core_stall if a core request is present.
REQ-027 SHALL drive o_core_stall and o_host_gnt combinationally in the issue cycle; host holds req/we/addr/wdata stable until o_host_gnt.
REQ-028 SHALL, for core address with any bit >= ADDR_W set, issue no memory access, pulse o_addr_err next cycle, and for a load return o_core_rvld=1 with o_core_rdata=0 next cycle.
REQ-029 SHALL register a read tag (NONE/CORE/HOST) at issue; on the next cycle route i_mem_rdata to the tagged side and pulse its rvld only.
REQ-030 SHALL hold o_core_rdata/o_host_rdata at last returned value when rvld low.
REQ-031 SHALL permit back-to-back reads every cycle from either side with no bubble.

Reset
REQ-032 SHALL, on i_rst, clear counter and read tag; outputs o_mem_re, o_mem_we, o_host_gnt, o_core_stall, o_core_rvld, o_host_rvld, o_addr_err = 0; rdata and o_mem_addr/o_mem_wdata = 0.
REQ-033 SHALL, if reset falls on the cycle after a read issue, suppress that return (no rvld).
REQ-034 SHALL ignore all requests while i_rst high.

Configuration
REQ-035 SHALL compile starvation guard (REQ-025/026) only when ARB_STARVE_GUARD_EN is defined; undefined: strict core priority, no counter, host served only when core idle.

Verification
REQ-036 Core load addr 5 and host write addr 7 same cycle, counter 0 -> mem_re addr 5, o_core_stall 0, o_host_gnt 0; next cycle core rvld with mem[5].
REQ-037 Core requests continuously, host req held, STARVE_MAX=8 -> host granted on 9th cycle of req, o_core_stall=1 that cycle only (guard defined); never granted with guard undefined.
REQ-038 Core load addr 0x400 (ADDR_W=10) -> no mem access, next cycle o_addr_err=1, o_core_rvld=1, o_core_rdata=0.
REQ-039 Host write 0xDEADBEEF to addr 3, then host read addr 3 -> o_host_rvld one cycle after grant, rdata 0xDEADBEEF, o_core_rvld stays 0.
REQ-040 Core read issued, i_rst asserted next cycle -> no rvld on either side; all outputs 0.
REQ-041 Alternating core read addr 1 / host read addr 2 every cycle with core idle gaps -> each rvld routed to correct side, no lost or duplicated returns.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port line-memory arbiter between a core (priority) and a host loader/debug port.
// Define ARB_STARVE_GUARD_EN to force a host grant after STARVE_MAX consecutive host wait cycles.
module mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_core_re,
    input  logic              i_core_we,
    input  logic [31:0]       i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic              o_core_stall,
    output logic [DATA_W-1:0] o_core_rdata,
    output logic              o_core_rvld,
    output logic              o_addr_err,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_gnt,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic              o_host_rvld,
    output logic              o_mem_re,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);
    // Read tag: who owns the data arriving on i_mem_rdata this cycle.
    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_CORE = 2'd1;
    localparam logic [1:0] TAG_HOST = 2'd2;
    localparam logic [1:0] TAG_CERR = 2'd3;

    logic              core_req, core_load, core_bad;
    logic              force_host, core_go, core_mem, host_go;
    logic [1:0]        tag_d, tag_q;
    logic              err_d, err_q;
    logic [DATA_W-1:0] core_hold_q, host_hold_q;

    assign core_req  = i_core_re | i_core_we;
    assign core_load = i_core_re & ~i_core_we;
    assign core_bad  = |i_core_addr[31:ADDR_W];

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    logic [7:0] starve_d, starve_q;

    assign force_host = i_host_req && (starve_q == STARVE_LIM);

    always_comb begin
        starve_d = starve_q;
        if (!i_host_req || host_go)
            starve_d = '0;
        else if (starve_q != STARVE_LIM)
            starve_d = starve_q + 8'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`else
    assign force_host = 1'b0;
`endif

    assign core_go      = ~i_rst & core_req & ~force_host;
    assign core_mem     = core_go & ~core_bad;
    assign host_go      = ~i_rst & i_host_req & (force_host | ~core_req);
    assign o_core_stall = ~i_rst & core_req & force_host;
    assign o_host_gnt   = host_go;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        o_mem_re    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        tag_d       = TAG_NONE;
        if (core_mem) begin
            o_mem_re    = core_load;
            o_mem_we    = i_core_we;
            o_mem_addr  = i_core_addr[ADDR_W-1:0];
            o_mem_wdata = i_core_we ? i_core_wdata : '0;
        end else if (host_go) begin
            o_mem_re    = ~i_host_we;
            o_mem_we    = i_host_we;
            o_mem_addr  = i_host_addr;
            o_mem_wdata = i_host_we ? i_host_wdata : '0;
        end
        if (core_go && core_load)
            tag_d = core_bad ? TAG_CERR : TAG_CORE;
        else if (host_go && !i_host_we)
            tag_d = TAG_HOST;
    end

    assign err_d = core_go & core_bad;

    // Return path: the live value on the rvld cycle, otherwise the last returned value.
    assign o_core_rvld  = ~i_rst & ((tag_q == TAG_CORE) | (tag_q == TAG_CERR));
    assign o_host_rvld  = ~i_rst & (tag_q == TAG_HOST);
    assign o_addr_err   = ~i_rst & err_q;
    assign o_core_rdata = i_rst               ? '0          :
                          (tag_q == TAG_CORE) ? i_mem_rdata :
                          (tag_q == TAG_CERR) ? '0          : core_hold_q;
    assign o_host_rdata = i_rst               ? '0          :
                          (tag_q == TAG_HOST) ? i_mem_rdata : host_hold_q;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tag_q       <= TAG_NONE;
            err_q       <= 1'b0;
            core_hold_q <= '0;
            host_hold_q <= '0;
        end else begin
            tag_q <= tag_d;
            err_q <= err_d;
            if (o_core_rvld) core_hold_q <= o_core_rdata;
            if (o_host_rvld) host_hold_q <= o_host_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a cycle model.
module tb_mem_arbiter;
    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 8;
    localparam int DEPTH      = 1 << ADDR_W;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              core_re = 0, core_we = 0;
    logic [31:0]       core_addr = '0;
    logic [DATA_W-1:0] core_wdata = '0;
    logic              host_req = 0, host_we = 0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              stall, core_rvld, addr_err, gnt, host_rvld, mem_re, mem_we;
    logic [DATA_W-1:0] core_rdata, host_rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_core_re(core_re), .i_core_we(core_we), .i_core_addr(core_addr), .i_core_wdata(core_wdata),
        .o_core_stall(stall), .o_core_rdata(core_rdata), .o_core_rvld(core_rvld), .o_addr_err(addr_err),
        .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
        .o_host_gnt(gnt), .o_host_rdata(host_rdata), .o_host_rvld(host_rvld),
        .o_mem_re(mem_re), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    // Environment memory: 1-cycle read latency, unwritten words derive from a per-run salt.
    logic [DATA_W-1:0] salt = '0;
    function automatic logic [DATA_W-1:0] seed_word(input logic [ADDR_W-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ salt;
    endfunction

    logic [DATA_W-1:0] env_mem [DEPTH];
    bit                env_wr  [DEPTH];
    always @(posedge clk) begin
        if (mem_we) begin
            env_mem[mem_addr] <= mem_wdata;
            env_wr[mem_addr]  <= 1'b1;
        end
        if (mem_re) mem_rdata <= env_wr[mem_addr] ? env_mem[mem_addr] : seed_word(mem_addr);
    end

    // Reference model state.
    int unsigned       n_cmp = 0, n_err = 0;
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                starve = 0;
    bit                pend_core = 0, pend_host = 0, pend_err = 0, last_host_gnt = 0;
    logic [DATA_W-1:0] pend_core_data = '0, pend_host_data = '0, core_hold = '0, host_hold = '0;
    bit                seen_gnt = 0, seen_core_rvld = 0, seen_host_rvld = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit cre, input bit cwe, input logic [31:0] caddr, input logic [DATA_W-1:0] cwd,
                         input bit hreq, input bit hwe, input logic [ADDR_W-1:0] haddr,
                         input logic [DATA_W-1:0] hwd);
        core_re = cre; core_we = cwe; core_addr = caddr; core_wdata = cwd;
        host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd;
    endtask

    task automatic idle();
        drive(0, 0, 32'd0, '0, 0, 0, '0, '0);
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model past the edge.
    task automatic cycle();
        bit creq, cload, bad, force_h, e_re, e_we;
        int owner;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata;
        @(negedge clk);
        creq    = core_re | core_we;
        cload   = core_re & ~core_we;
        bad     = core_addr >= DEPTH;
        force_h = GUARD && host_req && (starve == STARVE_MAX);
        owner   = 0;
        if (!rst) begin
            if (force_h)       owner = 2;
            else if (creq)     owner = 1;
            else if (host_req) owner = 2;
        end
        e_re = 0; e_we = 0; e_addr = '0; e_wdata = '0;
        if (owner == 1 && !bad) begin
            e_re = cload; e_we = core_we; e_addr = core_addr[ADDR_W-1:0]; e_wdata = core_we ? core_wdata : '0;
        end else if (owner == 2) begin
            e_re = !host_we; e_we = host_we; e_addr = host_addr; e_wdata = host_we ? host_wdata : '0;
        end
        seen_gnt = gnt; seen_core_rvld = core_rvld; seen_host_rvld = host_rvld;
        check("host_gnt", gnt, owner == 2);
        check("core_stall", stall, !rst && force_h && creq);
        check("mem_re", mem_re, e_re);
        check("mem_we", mem_we, e_we);
        if (e_re || e_we || rst) check("mem_addr", mem_addr, e_addr);
        if (e_we || rst)         check("mem_wdata", mem_wdata, e_wdata);
        check("core_rvld", core_rvld, !rst && pend_core);
        check("core_rdata", core_rdata, rst ? '0 : (pend_core ? pend_core_data : core_hold));
        check("host_rvld", host_rvld, !rst && pend_host);
        check("host_rdata", host_rdata, rst ? '0 : (pend_host ? pend_host_data : host_hold));
        check("addr_err", addr_err, !rst && pend_err);
        @(posedge clk);
        #1;
        if (rst) begin
            starve = 0; pend_core = 0; pend_host = 0; pend_err = 0;
            core_hold = '0; host_hold = '0; last_host_gnt = 0;
        end else begin
            if (pend_core) core_hold = pend_core_data;
            if (pend_host) host_hold = pend_host_data;
            pend_core      = (owner == 1) && cload;
            pend_core_data = bad ? '0 : ref_mem[core_addr[ADDR_W-1:0]];
            pend_err       = (owner == 1) && bad;
            pend_host      = (owner == 2) && !host_we;
            pend_host_data = ref_mem[host_addr];
            if (e_we) ref_mem[e_addr] = e_wdata;
            if (!host_req || owner == 2) starve = 0;
            else if (starve < STARVE_MAX) starve = starve + 1;
            last_host_gnt = (owner == 2);
        end
    endtask

    initial begin
        int grant_at, core_rets, host_rets, r;
        salt = $urandom;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i[ADDR_W-1:0]);
        idle();
        @(posedge clk);
        #1;

        // Requests during reset are ignored and every output stays low.
        drive(1, 0, 32'd5, '0, 1, 1, 10'd7, 32'h1111_1111);
        cycle();
        cycle();
        rst = 0;
        idle();
        cycle();

        // Core load 5 beats a same-cycle host write 7; host then goes through while core is idle.
        drive(1, 0, 32'd5, '0, 1, 1, 10'd7, 32'h1234_5678);
        cycle();
        drive(0, 0, 32'd0, '0, 1, 1, 10'd7, 32'h1234_5678);
        cycle();
        idle();
        cycle();

        // Host write then read-back of address 3.
        drive(0, 0, 32'd0, '0, 1, 1, 10'd3, 32'hDEAD_BEEF);
        cycle();
        drive(0, 0, 32'd0, '0, 1, 0, 10'd3, '0);
        cycle();
        idle();
        cycle();
        check("host_readback", host_rdata, 32'hDEAD_BEEF);

        // Out-of-range core load returns zero with an error pulse.
        drive(1, 0, 32'h0000_0400, '0, 0, 0, '0, '0);
        cycle();
        idle();
        cycle();

        // Continuous core loads against a held host read.
        grant_at = 0;
        for (int k = 1; k <= 12; k++) begin
            drive(1, 0, 32'($urandom_range(0, 15)), '0, grant_at == 0, 0, 10'd9, '0);
            cycle();
            if (seen_gnt && grant_at == 0) grant_at = k;
        end
        idle();
        cycle();
        check("starve_grant_cycle", grant_at, GUARD ? STARVE_MAX + 1 : 0);

        // Reset lands on the cycle after a core read issue: that return is dropped.
        drive(1, 0, 32'd1, '0, 0, 0, '0, '0);
        cycle();
        rst = 1;
        idle();
        cycle();
        rst = 0;
        cycle();

        // Alternating core/host reads with idle gaps; count returns per side.
        core_rets = 0;
        host_rets = 0;
        for (int k = 0; k < 13; k++) begin
            case (k % 3)
                0:       drive(1, 0, 32'd1, '0, 0, 0, '0, '0);
                1:       drive(0, 0, 32'd0, '0, 1, 0, 10'd2, '0);
                default: idle();
            endcase
            cycle();
            if (seen_core_rvld) core_rets++;
            if (seen_host_rvld) host_rets++;
        end
        check("alt_core_returns", core_rets, 4);
        check("alt_host_returns", host_rets, 4);

        // Randomized traffic; the host keeps its request stable until granted.
        for (int n = 0; n < 600; n++) begin
            if (!(host_req && !last_host_gnt)) begin
                host_req   = $urandom_range(0, 2) != 0;
                host_we    = $urandom_range(0, 1) == 1;
                host_addr  = ADDR_W'($urandom_range(0, 15));
                host_wdata = $urandom;
            end
            r          = $urandom_range(0, 9);
            core_re    = r < 4;
            core_we    = (r >= 3) && (r <= 5);
            core_addr  = ($urandom_range(0, 19) == 0) ? 32'h400 + $urandom_range(0, 1 << 20)
                                                      : 32'($urandom_range(0, 15));
            core_wdata = $urandom;
            rst        = $urandom_range(0, 99) == 0;
            cycle();
        end
        rst = 0;
        idle();
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
